// File: rtl/spi_tx_scheduler_if.sv
// Signal bundle between spi_tx_scheduler, its requesters and the shared serial TX engine.
// The master modport is the scheduler's view; slave is the client/engine side.
interface spi_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) ();
  localparam int PW = $clog2(NREQ);

  // Handshake: requester i raises req[i] with its req_data slice stable and holds
  // both until gnt[i] pulses; data is taken on that grant edge only. Dropping req
  // before the grant withdraws it. tx_start is a one-cycle strobe, tx_data holds
  // until a one-cycle tx_done is seen while the scheduler waits on the engine.
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    cs_n;
  logic               tx_start;
  logic [DW-1:0]      tx_data;
  logic               tx_done;
  logic [PW-1:0]      owner;
  logic               busy;
  logic               err;
  logic [1:0]         state;

  modport master (
    input  req, req_data, tx_done,
    output gnt, cs_n, tx_start, tx_data, owner, busy, err, state
  );

  modport slave (
    output req, req_data, tx_done,
    input  gnt, cs_n, tx_start, tx_data, owner, busy, err, state
  );
endinterface

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one serial TX engine among NREQ requesters.
// Optional watchdog on the engine wait is enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  spi_tx_scheduler_if.master bus
);
  localparam int PW = $clog2(NREQ);
  localparam int IW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          state;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] cs_n_q;
  logic            tx_start_q;
  logic [DW-1:0]   tx_data_q;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   rr_ptr;
  logic            busy_q;
  logic            err_q;
  logic [7:0]      gap_cnt;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic [IW-1:0]   idx;
  logic [PW-1:0]   next_ptr;
  logic            tm_hit;

  // First set request at or above rr_ptr, wrapping; idx never exceeds 2*NREQ-2.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!win_vld && bus.req[idx[PW-1:0]]) begin
        win     = idx[PW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tm_cnt;
  assign tm_hit = (tm_cnt == TW'(TIMEOUT - 1));
`else
  // Watchdog absent: TIMEOUT is a non-negative count, so this is constant 0.
  assign tm_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt_q      <= '0;
      cs_n_q     <= '1;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      owner_q    <= '0;
      rr_ptr     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      gap_cnt    <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      tm_cnt     <= '0;
`endif
    end else begin
      gnt_q <= '0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            gnt_q[win]  <= 1'b1;
            cs_n_q      <= '1;
            cs_n_q[win] <= 1'b0;
            tx_data_q   <= bus.req_data[win*DW +: DW];
            owner_q     <= win;
            busy_q      <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          tx_start_q <= 1'b1;
          state      <= S_WAIT;
`ifdef SPI_SCHED_TIMEOUT_EN
          tm_cnt     <= '0;
`endif
        end
        S_WAIT: begin
          tx_start_q <= 1'b0;
          // tx_done has priority, so err only fires on a genuine timeout.
          if (bus.tx_done || tm_hit) begin
            err_q   <= ~bus.tx_done;
            cs_n_q  <= '1;
            rr_ptr  <= next_ptr;
            gap_cnt <= '0;
            if (GAP == 0) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              state  <= S_GAP;
            end
          end
`ifdef SPI_SCHED_TIMEOUT_EN
          else begin
            tm_cnt <= tm_cnt + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (gap_cnt == 8'(GAP - 1)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.state    = state;
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Self-checking bench for spi_tx_scheduler: scenario tasks plus a grant/data scoreboard.
module tb_spi_tx_scheduler;
  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;
  localparam int PW      = 2;
  localparam int SW      = PW + DW;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail  = 0;
  int cs_viol = 0;
  logic [SW-1:0] exp_q[$];
  logic [DW-1:0] dat[NREQ];

  spi_tx_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus();

  spi_tx_scheduler #(
    .NREQ(NREQ), .DW(DW), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && ($countones(~bus.cs_n) > 1)) cs_viol++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise req[i] with fresh data and record the expected grant.
  task automatic post(input int i, input logic [DW-1:0] d);
    dat[i] = d;
    bus.req_data[i*DW +: DW] = d;
    bus.req[i] = 1'b1;
    exp_q.push_back({PW'(i), d});
  endtask

  // Wait for a grant, check it against the scoreboard, then play the engine.
  task automatic serve_frame(input int eng_len, input logic [NREQ-1:0] also_drop, input bit hold);
    logic [SW-1:0]   e;
    logic [NREQ-1:0] oh;
    logic [PW-1:0]   ei;
    logic [DW-1:0]   ed;
    int b;
    int unstable;
    b = 0;
    unstable = 0;
    while (bus.gnt == '0 && b < 100) begin
      tick();
      b++;
    end
    n_tests++;
    if (bus.gnt == '0 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL grant_wait: got gnt=%b with %0d expected pending, required a grant", bus.gnt, exp_q.size());
      return;
    end
    e  = exp_q.pop_front();
    ei = e[SW-1:DW];
    ed = e[DW-1:0];
    oh = '0;
    oh[ei] = 1'b1;
    n_tests++;
    if (bus.gnt !== oh || bus.owner !== ei) begin
      n_fail++;
      $display("FAIL grant_order: got gnt=%b owner=%0d, required gnt=%b owner=%0d", bus.gnt, bus.owner, oh, ei);
    end
    n_tests++;
    if (bus.cs_n !== ~oh) begin
      n_fail++;
      $display("FAIL cs_select: got cs_n=%b, required %b", bus.cs_n, ~oh);
    end
    if (!hold) bus.req = bus.req & ~bus.gnt & ~also_drop;
    tick();
    n_tests++;
    if (bus.tx_start !== 1'b1 || bus.gnt !== '0 || bus.tx_data !== ed) begin
      n_fail++;
      $display("FAIL tx_start: got start=%b gnt=%b data=%h, required start=1 gnt=0 data=%h",
               bus.tx_start, bus.gnt, bus.tx_data, ed);
    end
    for (int k = 1; k < eng_len; k++) begin
      tick();
      if (bus.tx_start !== 1'b0 || bus.tx_data !== ed || bus.cs_n !== ~oh) unstable++;
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL tx_hold: got %0d unstable engine cycles, required 0", unstable);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n_tests++;
    if (bus.cs_n !== '1) begin
      n_fail++;
      $display("FAIL cs_release: got cs_n=%b, required 1111", bus.cs_n);
    end
  endtask

  task automatic measure_gap(output int g);
    g = 0;
    while (bus.cs_n == '1 && g < 50) begin
      g++;
      tick();
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (bus.busy !== 1'b0 && b < 200) begin
      tick();
      b++;
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: got busy=%b after %0d cycles, required 0", bus.busy, b);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.cs_n !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_sel: got gnt=%b cs_n=%b, required 0000/1111", bus.gnt, bus.cs_n);
    end
    n_tests++;
    if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 || bus.owner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_tx: got start=%b data=%h owner=%0d, required 0/00/0", bus.tx_start, bus.tx_data, bus.owner);
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b err=%b state=%0d, required 0/0/0", bus.busy, bus.err, bus.state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    post(0, 8'hA5);
    serve_frame(10, '0, 1'b0);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_k1: got %b, required 1", bus.busy);
    end
    tick();
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_k3: got %b, required 0", bus.busy);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int g;
    do_reset();
    for (int i = 0; i < NREQ; i++) post(i, 8'($urandom_range(0, 255)));
    exp_q.push_back({PW'(0), dat[0]});
    for (int f = 0; f < 4; f++) begin
      serve_frame($urandom_range(1, 6), '0, 1'b1);
      measure_gap(g);
      n_tests++;
      if (g != GAP + 1) begin
        n_fail++;
        $display("FAIL b2b_gap%0d: got %0d cs-high cycles, required %0d", f, g, GAP + 1);
      end
    end
    bus.req = '0;
    serve_frame(3, '0, 1'b1);
    wait_idle();
  endtask

  task automatic test_rr_ptr();
    post(0, 8'($urandom_range(0, 255)));
    serve_frame(2, '0, 1'b0);
    wait_idle();
    post(2, 8'($urandom_range(0, 255)));
    post(0, 8'($urandom_range(0, 255)));
    serve_frame($urandom_range(1, 5), '0, 1'b0);
    serve_frame($urandom_range(1, 5), '0, 1'b0);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int b;
    int stray;
    b = 0;
    stray = 0;
    bus.req_data[1*DW +: DW] = 8'h3C;
    bus.req[1] = 1'b1;
    while (bus.gnt == '0 && b < 50) begin
      tick();
      b++;
    end
    bus.req = '0;
    tick();
    tick();
    n_tests++;
    if (bus.cs_n !== 4'b1101 || bus.state !== ST_WAIT) begin
      n_fail++;
      $display("FAIL mid_pre: got cs_n=%b state=%0d, required 1101/2", bus.cs_n, bus.state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.cs_n !== 4'b1111 || bus.tx_start !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got cs_n=%b start=%b busy=%b, required 1111/0/0", bus.cs_n, bus.tx_start, bus.busy);
    end
    // Requester 3 withdraws in the cycle requester 1 is granted.
    post(1, 8'($urandom_range(0, 255)));
    bus.req_data[3*DW +: DW] = 8'($urandom_range(0, 255));
    bus.req[3] = 1'b1;
    serve_frame(4, 4'b1000, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.gnt !== '0) stray++;
    end
    n_tests++;
    if (stray != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw: got %0d stray grants busy=%b, required 0/0", stray, bus.busy);
    end
  endtask

  task automatic test_spurious_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n_tests++;
    if (bus.state !== ST_IDLE || bus.busy !== 1'b0 || bus.cs_n !== '1 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_done: got state=%0d busy=%b cs_n=%b err=%b, required 0/0/1111/0",
               bus.state, bus.busy, bus.cs_n, bus.err);
    end
    tick();
    n_tests++;
    if (bus.tx_start !== 1'b0 || bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL spurious_after: got start=%b gnt=%b, required 0/0000", bus.tx_start, bus.gnt);
    end
  endtask

  task automatic test_timeout();
    int b;
    int n;
    b = 0;
    n = 0;
    bus.req_data[0 +: DW] = 8'h5A;
    bus.req[0] = 1'b1;
    while (bus.gnt == '0 && b < 50) begin
      tick();
      b++;
    end
    bus.req = '0;
    tick();
    n_tests++;
    if (bus.tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL to_start: got %b, required 1", bus.tx_start);
    end
`ifdef SPI_SCHED_TIMEOUT_EN
    while (bus.err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != TIMEOUT || bus.cs_n !== '1) begin
      n_fail++;
      $display("FAIL to_err: got err after %0d cycles cs_n=%b, required %0d/1111", n, bus.cs_n, TIMEOUT);
    end
    tick();
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse: got err=%b one cycle later, required 0", bus.err);
    end
    wait_idle();
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.err !== 1'b0) n++;
    end
    n_tests++;
    if (n != 0 || bus.state !== ST_WAIT || bus.cs_n !== 4'b1110) begin
      n_fail++;
      $display("FAIL to_hold: got %0d err cycles state=%0d cs_n=%b, required 0/2/1110", n, bus.state, bus.cs_n);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    wait_idle();
`endif
  endtask

  task automatic test_final();
    n_tests++;
    if (cs_viol != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final: got %0d multi-cs cycles, %0d grants outstanding, required 0/0", cs_viol, exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_ptr();
    test_reset_mid();
    test_spurious_done();
    test_timeout();
    test_final();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
